// File: rtl/tiny_dnn_pkg.sv
// Shared encodings and constants for the tiny_dnn_core command scheduler.
package tiny_dnn_pkg;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_INIT  = 2'b01;
    localparam logic [1:0] OP_EXEC  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    // Cycles an EXEC waits for any busy bit before assuming an empty exec.
    localparam int WAIT_RISE_MAX = 4;

    // Core select field inside the core address.
    localparam int BANK_LSB = 9;
    localparam int BANK_W   = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RISE = 3'd2,
        WAIT_BUSY = 3'd3,
        RD_CAP    = 3'd4,
        RSP       = 3'd5
    } state_e;

endpackage

// File: rtl/tiny_dnn_cmd_fifo.sv
// Command FIFO with occupancy output; ready deasserts when full, with no
// write-through bypass even if a pop happens in the same cycle.
module tiny_dnn_cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int LW    = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             push_s;
    logic             pop_s;

    assign push_ready_o = (level_q != LW'(DEPTH));
    assign empty_o      = (level_q == LW'(0));
    assign push_s       = push_valid_i & push_ready_o;
    assign pop_s        = pop_i & ~empty_o;
    assign head_o       = mem_q[rd_ptr_q];
    assign level_o      = level_q;

    // Storage, pointers (wrap naturally at power-of-two depth) and level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= PW'(0);
            rd_ptr_q <= PW'(0);
            level_q  <= LW'(0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= WIDTH'(0);
            end
        end else begin
            if (push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/tiny_dnn_sched.sv
// Command scheduler for the tiny_dnn_core array: FIFO-buffered commands become
// one-cycle strobes gated on array busy; reads return via valid/ready.
// Optional exec cycle counter enabled by TINY_DNN_SCHED_PERF_EN.
module tiny_dnn_sched
    import tiny_dnn_pkg::*;
#(
    parameter int F_NUM = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 13,
    parameter int DW    = 16
) (
    input  logic                   S_AXI_ACLK,
    input  logic                   S_AXI_ARESETN,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [1:0]             cmd_op,
    input  logic [AW-1:0]          cmd_addr,
    input  logic [DW-1:0]          cmd_data,
    output logic                   core_write,
    output logic                   core_read,
    output logic                   core_init,
    output logic                   core_exec,
    output logic [AW-1:0]          core_a,
    output logic [DW-1:0]          core_d,
    input  logic [F_NUM-1:0]       core_busy,
    input  logic [F_NUM*DW-1:0]    core_w,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DW-1:0]          rsp_data,
    output logic [$clog2(DEPTH):0] q_level
`ifdef TINY_DNN_SCHED_PERF_EN
    ,
    output logic [31:0]            exec_cycles
`endif
);

    localparam int CW   = 2 + AW + DW;
    localparam int RC_W = $clog2(WAIT_RISE_MAX);

    logic [CW-1:0]     fifo_in_s;
    logic [CW-1:0]     fifo_head_s;
    logic              fifo_empty_s;
    logic              pop_s;
    logic              busy_any_s;

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [RC_W-1:0]   rise_cnt_q, rise_cnt_d;
    logic              write_q, write_d;
    logic              read_q, read_d;
    logic              init_q, init_d;
    logic              exec_q, exec_d;
    logic [AW-1:0]     core_a_q, core_a_d;
    logic [DW-1:0]     core_d_q, core_d_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;

    assign fifo_in_s  = {cmd_op, cmd_addr, cmd_data};
    assign busy_any_s = |core_busy;

    tiny_dnn_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CW)
    ) u_fifo (
        .clk          (S_AXI_ACLK),
        .rst_n        (S_AXI_ARESETN),
        .push_valid_i (cmd_valid),
        .push_ready_o (cmd_ready),
        .push_data_i  (fifo_in_s),
        .pop_i        (pop_s),
        .head_o       (fifo_head_s),
        .empty_o      (fifo_empty_s),
        .level_o      (q_level)
    );

    // Next-state and registered-output computation for the dispatch FSM.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        data_d      = data_q;
        bank_d      = bank_q;
        rise_cnt_d  = rise_cnt_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        init_d      = 1'b0;
        exec_d      = 1'b0;
        core_a_d    = core_a_q;
        core_d_d    = core_d_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        pop_s       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty_s && !busy_any_s) begin
                    pop_s                   = 1'b1;
                    {op_d, addr_d, data_d}  = fifo_head_s;
                    state_d                 = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                // Hold off if busy rose between the pop and the strobe.
                if (busy_any_s) begin
                    state_d = ISSUE;
                end else begin
                    core_a_d   = addr_q;
                    core_d_d   = data_q;
                    rise_cnt_d = RC_W'(0);
                    case (op_q)
                        OP_WRITE: begin
                            write_d = 1'b1;
                            state_d = IDLE;
                        end
                        OP_INIT: begin
                            init_d  = 1'b1;
                            state_d = IDLE;
                        end
                        OP_EXEC: begin
                            exec_d  = 1'b1;
                            state_d = WAIT_RISE;
                        end
                        OP_READ: begin
                            read_d  = 1'b1;
                            bank_d  = addr_q[BANK_LSB +: BANK_W];
                            state_d = RD_CAP;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
            WAIT_RISE: begin
                if (busy_any_s || (rise_cnt_q == RC_W'(WAIT_RISE_MAX - 1))) begin
                    state_d = WAIT_BUSY;
                end else begin
                    rise_cnt_d = rise_cnt_q + RC_W'(1);
                end
            end
            WAIT_BUSY: begin
                if (!busy_any_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_BUSY;
                end
            end
            RD_CAP: begin
                rsp_data_d  = core_w[bank_q*DW +: DW];
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RSP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state, head latch and registered strobe/response outputs.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            addr_q      <= AW'(0);
            data_q      <= DW'(0);
            bank_q      <= BANK_W'(0);
            rise_cnt_q  <= RC_W'(0);
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            init_q      <= 1'b0;
            exec_q      <= 1'b0;
            core_a_q    <= AW'(0);
            core_d_q    <= DW'(0);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= DW'(0);
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            bank_q      <= bank_d;
            rise_cnt_q  <= rise_cnt_d;
            write_q     <= write_d;
            read_q      <= read_d;
            init_q      <= init_d;
            exec_q      <= exec_d;
            core_a_q    <= core_a_d;
            core_d_q    <= core_d_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign core_write = write_q;
    assign core_read  = read_q;
    assign core_init  = init_q;
    assign core_exec  = exec_q;
    assign core_a     = core_a_q;
    assign core_d     = core_d_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;

`ifdef TINY_DNN_SCHED_PERF_EN
    logic [31:0] exec_cycles_q;

    // Saturating count of cycles spent waiting on an exec; cleared by init.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            exec_cycles_q <= 32'h0000_0000;
        end else if (init_q) begin
            exec_cycles_q <= 32'h0000_0000;
        end else if (((state_q == WAIT_RISE) || (state_q == WAIT_BUSY)) &&
                     (exec_cycles_q != 32'hFFFF_FFFF)) begin
            exec_cycles_q <= exec_cycles_q + 32'h0000_0001;
        end
    end

    assign exec_cycles = exec_cycles_q;
`endif

endmodule

// File: tb/tb_tiny_dnn_sched.sv
// Self-checking bench for tiny_dnn_sched: directed scenarios plus a randomized
// phase compared against a queue-based command/response reference model.
module tb_tiny_dnn_sched;
    import tiny_dnn_pkg::*;

    localparam int F_NUM = 16;
    localparam int DEPTH = 4;
    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [1:0]    op;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [AW-1:0]       cmd_addr;
    logic [DW-1:0]       cmd_data;
    logic                core_write, core_read, core_init, core_exec;
    logic [AW-1:0]       core_a;
    logic [DW-1:0]       core_d;
    logic [F_NUM-1:0]    core_busy;
    logic [F_NUM*DW-1:0] core_w;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [DW-1:0]       rsp_data;
    logic [LW-1:0]       q_level;
`ifdef TINY_DNN_SCHED_PERF_EN
    logic [31:0]         exec_cycles;
`endif

    logic             busy_man = 1'b0;
    logic             busy_auto = 1'b0;
    logic [F_NUM-1:0] busy_mask = 16'h0001;
    logic [DW-1:0]    lane [F_NUM];

    cmd_t          exp_q[$];
    cmd_t          obs_q[$];
    logic [DW-1:0] exp_rsp[$];
    logic [DW-1:0] obs_rsp[$];

    int checks = 0;
    int errors = 0;
    int viol = 0;
    int cyc = 0;
    bit auto_en = 1'b0;
    int busy_left = 0;

    assign core_busy = (busy_man | busy_auto) ? busy_mask : '0;

    always_comb begin
        for (int i = 0; i < F_NUM; i++) core_w[i*DW +: DW] = lane[i];
    end

    always #5 clk = ~clk;

    tiny_dnn_sched #(.F_NUM(F_NUM), .DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .core_write    (core_write),
        .core_read     (core_read),
        .core_init     (core_init),
        .core_exec     (core_exec),
        .core_a        (core_a),
        .core_d        (core_d),
        .core_busy     (core_busy),
        .core_w        (core_w),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .q_level       (q_level)
`ifdef TINY_DNN_SCHED_PERF_EN
        ,
        .exec_cycles   (exec_cycles)
`endif
    );

    // Strobe/response monitor; strobes must be one-hot and never overlap busy.
    always @(negedge clk) begin : mon
        cmd_t       c;
        logic [2:0] n;
        if (rst_n) begin
            n = 3'(core_write) + 3'(core_read) + 3'(core_init) + 3'(core_exec);
            if (n != 3'd0) begin
                c.op = core_write ? OP_WRITE : core_init ? OP_INIT : core_exec ? OP_EXEC : OP_READ;
                c.a  = core_a;
                c.d  = core_d;
                obs_q.push_back(c);
                if (n != 3'd1 || core_busy != '0) viol++;
            end
            if (rsp_valid && rsp_ready) obs_rsp.push_back(rsp_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; also plays a simple core (busy after exec) and a random consumer.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (auto_en) begin
            if (busy_left > 0) begin
                busy_auto = 1'b1;
                busy_left--;
            end else begin
                busy_auto = 1'b0;
            end
            if (core_exec && busy_left == 0 && $urandom_range(0, 3) != 0)
                busy_left = $urandom_range(1, 8);
            rsp_ready = ($urandom_range(0, 2) != 0);
        end
    endtask

    task automatic push(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int g = 0;
        cmd_op = op; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
        while (!cmd_ready && g < 300) begin
            tick();
            g++;
        end
        check("push_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back(cmd_t'({op, a, d}));
        if (op == OP_READ) exp_rsp.push_back(lane[a[12:9]]);
    endtask

    task automatic wait_obs(input int n, input int budget);
        int g = 0;
        while (obs_q.size() < n && g < budget) begin
            tick();
            g++;
        end
        check("wait_strobes", 32'(obs_q.size() >= n), 32'd1);
    endtask

    task automatic compare_logs(input string tag);
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            check(tag, 32'(obs_q[i]), 32'(exp_q[i]));
        check({tag, "_rsp_count"}, 32'(obs_rsp.size()), 32'(exp_rsp.size()));
        for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++)
            check({tag, "_rsp"}, 32'(obs_rsp[i]), 32'(exp_rsp[i]));
        exp_q.delete(); obs_q.delete(); exp_rsp.delete(); obs_rsp.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int g;
        int t0;
        int t1;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; rsp_ready = 1'b0;
        for (int i = 0; i < F_NUM; i++) lane[i] = 16'($urandom);
        #2 rst_n = 1'b0;
        tick(); tick();
        check("rst_q_level", 32'(q_level), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_strobes", 32'({core_write, core_read, core_init, core_exec}), 32'd0);
        check("rst_core_a", 32'(core_a), 32'd0);
        check("rst_core_d", 32'(core_d), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick(); tick();
        check("ready_idle_no_rsp", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Single WRITE: strobe exactly two cycles after the push edge.
        cmd_op = OP_WRITE; cmd_addr = 13'h0203; cmd_data = 16'h1234; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back(cmd_t'({OP_WRITE, 13'h0203, 16'h1234}));
        check("w1_level_after_push", 32'(q_level), 32'd1);
        check("w1_no_early_strobe", 32'(core_write), 32'd0);
        tick();
        check("w1_no_strobe_cyc1", 32'(core_write), 32'd0);
        tick();
        check("w1_core_write", 32'(core_write), 32'd1);
        check("w1_core_a", 32'(core_a), 32'h0203);
        check("w1_core_d", 32'(core_d), 32'h1234);
        check("w1_level", 32'(q_level), 32'd0);
        tick();
        check("w1_one_cycle", 32'(core_write), 32'd0);
        repeat (3) tick();
        compare_logs("w1_log");

        // EXEC followed by WRITE; write must wait out 20 busy cycles.
        push(OP_EXEC, 13'h1F00, 16'h5555);
        push(OP_WRITE, 13'h0011, 16'hA5A5);
        g = 0;
        while (!core_exec && g < 20) begin tick(); g++; end
        check("ex_exec_seen", 32'(core_exec), 32'd1);
        tick();
        busy_man = 1'b1;
        repeat (20) tick();
        check("ex_write_held_level", 32'(q_level), 32'd1);
        check("ex_write_held_log", 32'(obs_q.size()), 32'd1);
        busy_man = 1'b0;
        wait_obs(2, 20);
        compare_logs("ex_log");

        // READ bank 5 with a stalled consumer and a WRITE queued behind it.
        lane[5] = 16'hBEEF;
        push(OP_READ, 13'h0A05, 16'h0000);
        push(OP_WRITE, 13'h0022, 16'h0F0F);
        g = 0;
        while (!rsp_valid && g < 20) begin tick(); g++; end
        check("rd_valid", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("rd_hold_valid", 32'(rsp_valid), 32'd1);
            check("rd_hold_data", 32'(rsp_data), 32'hBEEF);
            tick();
        end
        check("rd_next_waits_level", 32'(q_level), 32'd1);
        check("rd_next_waits_log", 32'(obs_q.size()), 32'd1);
        rsp_ready = 1'b1;
        tick();
        check("rd_cleared", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;
        wait_obs(2, 20);
        compare_logs("rd_log");

        // Fill the FIFO while busy; a fifth command is refused.
        busy_man = 1'b1;
        for (int i = 0; i < 4; i++) push(OP_WRITE, AW'(i), 16'($urandom));
        check("full_level", 32'(q_level), 32'd4);
        check("full_ready", 32'(cmd_ready), 32'd0);
        cmd_op = OP_WRITE; cmd_addr = 13'h0004; cmd_data = 16'hDEAD; cmd_valid = 1'b1;
        tick(); tick();
        check("full_no_accept", 32'(q_level), 32'd4);
        cmd_valid = 1'b0;
        busy_man = 1'b0;
        wait_obs(4, 40);
        repeat (10) tick();
        compare_logs("full_log");

        // EXEC with no busy: 4 wait cycles, 1 settle, then pop/issue -> 7 cycles.
        push(OP_EXEC, 13'h0100, 16'h0001);
        push(OP_WRITE, 13'h0033, 16'h3333);
        g = 0;
        while (!core_exec && g < 20) begin tick(); g++; end
        check("empty_exec_seen", 32'(core_exec), 32'd1);
        t0 = cyc;
        g = 0;
        while (!core_write && g < 30) begin tick(); g++; end
        t1 = cyc;
        check("empty_exec_write", 32'(core_write), 32'd1);
        check("empty_exec_gap", 32'(t1 - t0), 32'd7);
        repeat (3) tick();
        compare_logs("empty_log");

        // Reset while waiting on busy with three commands queued.
        push(OP_EXEC, 13'h0200, 16'h0002);
        g = 0;
        while (!core_exec && g < 20) begin tick(); g++; end
        tick();
        busy_man = 1'b1;
        for (int i = 0; i < 3; i++) push(OP_WRITE, AW'(16 + i), 16'h00AA);
        check("rstq_level", 32'(q_level), 32'd3);
        rst_n = 1'b0;
        #1;
        check("rstq_strobes", 32'({core_write, core_read, core_init, core_exec}), 32'd0);
        check("rstq_level0", 32'(q_level), 32'd0);
        check("rstq_rsp_valid", 32'(rsp_valid), 32'd0);
        exp_q.delete(); obs_q.delete(); exp_rsp.delete(); obs_rsp.delete();
        tick();
        rst_n = 1'b1;
        busy_man = 1'b0;
        repeat (15) tick();
        check("rstq_no_issue", 32'(obs_q.size()), 32'd0);
        check("rstq_level_after", 32'(q_level), 32'd0);

        // Randomized traffic against the queue model.
        busy_mask = 16'($urandom_range(1, 65535));
        for (int i = 0; i < F_NUM; i++) lane[i] = 16'($urandom);
        auto_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            push(2'($urandom_range(0, 3)), 13'($urandom), 16'($urandom));
            repeat ($urandom_range(0, 3)) tick();
        end
        g = 0;
        while ((obs_q.size() != exp_q.size() || obs_rsp.size() != exp_rsp.size() ||
                q_level != '0) && g < 3000) begin
            tick();
            g++;
        end
        check("rand_drained", 32'(g < 3000), 32'd1);
        auto_en = 1'b0;
        busy_left = 0;
        busy_auto = 1'b0;
        rsp_ready = 1'b0;
        repeat (10) tick();
        compare_logs("rand_log");

        check("strobe_onehot_not_busy", 32'(viol), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tiny_dnn_sched.md
Name: tiny_dnn_sched

Overview:
- Command scheduler in front of the 16-core tiny_dnn_core array.
- Buffers write/init/exec/read commands from the AXI front-end in a small FIFO.
- Dispatches each command as a one-cycle core strobe, gated on array busy.
- Returns captured read data through a valid/ready response port, so the bus side never stalls on busy.

Parameters:
- F_NUM, 16: number of cores; core select is core_a[12:9].
- DEPTH, 4: command FIFO entries; power of two, minimum 2.
- AW, 13: core address width.
- DW, 16: weight data width.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_op  in  2  00 WRITE, 01 INIT, 10 EXEC, 11 READ.
- cmd_addr  in  AW  core address.
- cmd_data  in  DW  write data.
- core_write  out  1  write strobe.
- core_read  out  1  read strobe.
- core_init  out  1  init strobe, broadcast.
- core_exec  out  1  exec strobe, broadcast.
- core_a  out  AW  address for the strobe.
- core_d  out  DW  data for the strobe.
- core_busy  in  F_NUM  per-core busy.
- core_w  in  F_NUM*DW  per-core read data; core i at [i*DW +: DW].
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DW  read response.
- q_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO empty, q_level=0, state IDLE, all strobes 0, core_a=0, core_d=0, rsp_valid=0, rsp_data=0. Reset mid-exec or mid-read drops the operation; no response is produced.
- FIFO:
  - push = cmd_valid & cmd_ready; cmd_ready = (q_level != DEPTH).
  - Push and pop in the same cycle keeps q_level unchanged; this is legal even when full, but cmd_ready is still 0 when full (no bypass).
  - Pointers wrap modulo DEPTH.
- States: IDLE, ISSUE, WAIT_RISE, WAIT_BUSY, RD_CAP, RSP.
- IDLE:
  - Advances when the FIFO is non-empty and |core_busy == 0.
  - Pops the head into the op/addr/data registers and goes to ISSUE.
- ISSUE:
  - Exactly one strobe is high for one cycle, with core_a/core_d registered from the head.
  - core_write/core_read are issued with the full address; the core decodes a[12:9].
  - WRITE or INIT returns to IDLE.
  - EXEC goes to WAIT_RISE.
  - READ latches bank=addr[12:9] and goes to RD_CAP.
  - Dispatch latency from push into an empty, idle FIFO: strobe appears 2 cycles after the push edge.
- WAIT_RISE: waits for |core_busy; after 4 cycles without busy it falls through to WAIT_BUSY, which covers an empty exec.
- WAIT_BUSY: waits until |core_busy == 0, then returns to IDLE.
- RD_CAP: one cycle after core_read, captures rsp_data <= core_w[bank], sets rsp_valid, goes to RSP.
- RSP:
  - Holds rsp_valid/rsp_data until rsp_ready; then clears rsp_valid and returns to IDLE.
  - No dispatch occurs while a response is pending.
  - rsp_ready high while not valid has no effect.
- Ordering: commands execute strictly in push order. Strobes are never issued while any busy bit is high.
- Unused core_w lanes are ignored.

Optional Feature:
- Macro TINY_DNN_SCHED_PERF_EN.
- When defined:
  - Adds output exec_cycles[31:0], which counts cycles spent in WAIT_RISE+WAIT_BUSY, saturating at 32'hFFFFFFFF.
  - It clears on reset and on each core_init strobe.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package tiny_dnn_pkg holds:
  - op encodings OP_WRITE=2'b00, OP_INIT=2'b01, OP_EXEC=2'b10, OP_READ=2'b11;
  - the state enum;
  - WAIT_RISE_MAX=4.
- Sub-module tiny_dnn_cmd_fifo (parameterised DEPTH/width, level output). The FSM stays in tiny_dnn_sched.

Test Plan:
- Push WRITE a=13'h0203 d=16'h1234 into an idle FIFO -> core_write=1, core_a=0x0203, core_d=0x1234 for one cycle, 2 cycles after push; q_level returns to 0.
- Push EXEC, then WRITE, with core_busy driven high for 20 cycles starting 1 cycle after core_exec -> core_write fires only after busy falls, never during.
- Push READ a=13'h0A05 with core_w lane 5=16'hBEEF and rsp_ready low for 5 cycles -> rsp_valid held with rsp_data=0xBEEF, then cleared one cycle after rsp_ready; the next queued command waits for it.
- Push 4 WRITEs with core_busy held high (DEPTH=4) -> cmd_ready=0, q_level=4; a 5th cmd_valid is not accepted; after busy drops, the 4 strobes issue in order at addresses 0,1,2,3.
- Push EXEC with core_busy never rising -> returns to IDLE after 4 WAIT_RISE cycles; the next command dispatches.
- Assert S_AXI_ARESETN low during WAIT_BUSY with 3 queued commands -> all strobes 0 immediately, q_level=0, rsp_valid=0; no commands issue after release.
